// File: rtl/gb80_alu_pkg.sv
// Shared definitions for the Game Boy style ALU and the 16-bit sequencer.
// Holds the 8-bit ALU opcodes, F-register bit positions, 16-bit command
// encodings, the sequencer state encoding and the final flag composer.
package gb80_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_ADC = 3'd1,
        ALU_SUB = 3'd2,
        ALU_SBC = 3'd3,
        ALU_AND = 3'd4,
        ALU_XOR = 3'd5,
        ALU_OR  = 3'd6,
        ALU_CP  = 3'd7
    } alu_op_e;

    localparam int unsigned FLAG_Z = 7;
    localparam int unsigned FLAG_N = 6;
    localparam int unsigned FLAG_H = 5;
    localparam int unsigned FLAG_C = 4;

    typedef enum logic [1:0] {
        CMD_ADD16 = 2'd0,
        CMD_INC16 = 2'd1,
        CMD_DEC16 = 2'd2,
        CMD_ADDSP = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Builds the new F value. c16/h16 are the combined high-byte carry and
    // half-carry (high step OR fix step); c_lo/h_lo come from the low byte.
    function automatic logic [7:0] make_flags(
        input cmd_e       cmd,
        input logic [7:0] f_in,
        input logic       c16,
        input logic       h16,
        input logic       c_lo,
        input logic       h_lo
    );
        logic [7:0] f;
        f = '0;
        case (cmd)
            CMD_ADD16: begin
                f[FLAG_Z] = f_in[FLAG_Z];
                f[FLAG_H] = h16;
                f[FLAG_C] = c16;
            end
            CMD_INC16, CMD_DEC16: begin
                f = {f_in[7:4], 4'h0};
            end
            default: begin
                f[FLAG_H] = h_lo;
                f[FLAG_C] = c_lo;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu16_seq_if.sv
// Bus between the instruction decoder / shared 8-bit ALU and alu16_seq.
// master: decoder side (command request, ALU result return).
// slave : alu16_seq (ready/done/result, ALU operand drive).
interface alu16_seq_if
    import gb80_alu_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned DATA_WIDTH   = 8
);
    // Decoder command side
    logic                    i_valid;
    logic                    o_ready;
    cmd_e                    i_cmd;
    logic [15:0]             i_op_a;
    logic [15:0]             i_op_b;
    logic [7:0]              i_flags;
    logic                    o_done;
    logic [15:0]             o_result;
    logic [7:0]              o_flags;
    // Shared ALU side
    logic [DATA_WIDTH-1:0]   o_alu_a;
    logic [DATA_WIDTH-1:0]   o_alu_b;
    logic [OPCODE_WIDTH-1:0] o_alu_op;
    logic [DATA_WIDTH-1:0]   i_alu_result;
    logic [7:0]              i_alu_flags;

    modport master (
        output i_valid, i_cmd, i_op_a, i_op_b, i_flags, i_alu_result, i_alu_flags,
        input  o_ready, o_done, o_result, o_flags, o_alu_a, o_alu_b, o_alu_op
    );

    modport slave (
        input  i_valid, i_cmd, i_op_a, i_op_b, i_flags, i_alu_result, i_alu_flags,
        output o_ready, o_done, o_result, o_flags, o_alu_a, o_alu_b, o_alu_op
    );

endinterface

// File: rtl/alu16_seq.sv
// 16-bit arithmetic sequencer (ADD HL,rr / INC rr / DEC rr / ADD SP,e8)
// built on the shared 8-bit carry-less ALU. Low byte, then high byte, then
// an optional fix step that adds/subtracts 1 from the high byte when the
// low byte produced a carry/borrow.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - alu16_seq_if.slave: valid/ready command, operands, F in,
//            ALU operand drive and return, done pulse, result and F out
module alu16_seq
    import gb80_alu_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    alu16_seq_if.slave  bus
);

    state_e                state_q, state_n;
    logic [15:0]           a_q;
    logic [15:0]           b_q;
    logic [15:0]           b_eff;
    cmd_e                  cmd_q;
    logic [3:0]            flags_q;
    alu_op_e               op_q;
    alu_op_e               op_drv;
    logic [DATA_WIDTH-1:0] res_lo_q;
    logic [DATA_WIDTH-1:0] res_hi_q;
    logic                  c_lo_q, h_lo_q, c_hi_q, h_hi_q;
    logic                  done_q;
    logic [15:0]           result_q;
    logic [7:0]            oflags_q;
    logic                  accept;
    logic                  alu_c, alu_h;

    // Only H and C of the ALU flags and the high nibble of F are consumed.
    logic unused_bits;
    assign unused_bits = ^{bus.i_alu_flags[7:6], bus.i_alu_flags[3:0], bus.i_flags[3:0]};

    assign alu_c  = bus.i_alu_flags[FLAG_C];
    assign alu_h  = bus.i_alu_flags[FLAG_H];
    assign accept = (state_q == ST_IDLE) && bus.i_valid;

    always_comb begin
        case (bus.i_cmd)
            CMD_ADD16:            b_eff = bus.i_op_b;
            CMD_INC16, CMD_DEC16: b_eff = 16'h0001;
            default:              b_eff = {{8{bus.i_op_b[7]}}, bus.i_op_b[7:0]};
        endcase
    end

    always_comb begin
        state_n      = state_q;
        bus.o_ready  = 1'b0;
        bus.o_alu_a  = '0;
        bus.o_alu_b  = '0;
        op_drv       = ALU_ADD;
        case (state_q)
            ST_IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) state_n = ST_LO;
            end
            ST_LO: begin
                bus.o_alu_a = a_q[DATA_WIDTH-1:0];
                bus.o_alu_b = b_q[DATA_WIDTH-1:0];
                op_drv      = op_q;
                state_n     = ST_HI;
            end
            ST_HI: begin
                bus.o_alu_a = a_q[15:DATA_WIDTH];
                bus.o_alu_b = b_q[15:DATA_WIDTH];
                op_drv      = op_q;
                state_n     = c_lo_q ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                bus.o_alu_a = res_hi_q;
                bus.o_alu_b = DATA_WIDTH'(1);
                op_drv      = op_q;
                state_n     = ST_DONE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        bus.o_alu_op = OPCODE_WIDTH'(op_drv);
    end

    // The visible result/flags registers are loaded on the edge entering
    // DONE, straight from the final ALU step, so they hold until the next
    // completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= CMD_ADD16;
            flags_q  <= '0;
            op_q     <= ALU_ADD;
            res_lo_q <= '0;
            res_hi_q <= '0;
            c_lo_q   <= 1'b0;
            h_lo_q   <= 1'b0;
            c_hi_q   <= 1'b0;
            h_hi_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            oflags_q <= '0;
        end else begin
            state_q <= state_n;
            done_q  <= (state_n == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= bus.i_op_a;
                        b_q     <= b_eff;
                        cmd_q   <= bus.i_cmd;
                        flags_q <= bus.i_flags[7:4];
                        op_q    <= (bus.i_cmd == CMD_DEC16) ? ALU_SUB : ALU_ADD;
                    end
                end
                ST_LO: begin
                    res_lo_q <= bus.i_alu_result;
                    c_lo_q   <= alu_c;
                    h_lo_q   <= alu_h;
                end
                ST_HI: begin
                    res_hi_q <= bus.i_alu_result;
                    c_hi_q   <= alu_c;
                    h_hi_q   <= alu_h;
                    if (!c_lo_q) begin
                        result_q <= {bus.i_alu_result, res_lo_q};
                        oflags_q <= make_flags(cmd_q, {flags_q, 4'h0},
                                               alu_c, alu_h, c_lo_q, h_lo_q);
                    end
                end
                ST_FIX: begin
                    res_hi_q <= bus.i_alu_result;
                    result_q <= {bus.i_alu_result, res_lo_q};
                    oflags_q <= make_flags(cmd_q, {flags_q, 4'h0},
                                           c_hi_q | alu_c, h_hi_q | alu_h,
                                           c_lo_q, h_lo_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;
    assign bus.o_flags  = oflags_q;

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;
    import gb80_alu_pkg::*;

    logic clk;
    logic rst;

    alu16_seq_if #(.OPCODE_WIDTH(3), .DATA_WIDTH(8)) bus ();

    alu16_seq #(.OPCODE_WIDTH(3), .DATA_WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8-bit ALU (ADD and SUB only; C is borrow on SUB)
    logic [8:0] alu_sum;
    logic [7:0] alu_r;
    logic       alu_hh, alu_cc, alu_nn;
    always_comb begin
        alu_sum = '0;
        alu_r   = '0;
        alu_hh  = 1'b0;
        alu_cc  = 1'b0;
        alu_nn  = 1'b0;
        case (bus.o_alu_op)
            3'd0: begin
                alu_sum = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
                alu_r   = alu_sum[7:0];
                alu_cc  = alu_sum[8];
                alu_hh  = ({1'b0, bus.o_alu_a[3:0]} + {1'b0, bus.o_alu_b[3:0]}) > 5'h0F;
            end
            3'd2: begin
                alu_r  = bus.o_alu_a - bus.o_alu_b;
                alu_cc = bus.o_alu_a < bus.o_alu_b;
                alu_hh = bus.o_alu_a[3:0] < bus.o_alu_b[3:0];
                alu_nn = 1'b1;
            end
            default: ;
        endcase
        bus.i_alu_result = alu_r;
        bus.i_alu_flags  = {alu_r == 8'h00, alu_nn, alu_hh, alu_cc, 4'h0};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        for (int k = 0; k < 20 && !bus.o_ready; k++) @(negedge clk);
        check({nm, " ready"}, 32'(bus.o_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] f, input logic [15:0] er, input logic [7:0] ef,
                           input int elat, input string nm);
        int  lat;
        bit  seen;
        @(negedge clk);
        wait_ready(nm);
        bus.i_cmd   = cmd_e'(cmd);
        bus.i_op_a  = a;
        bus.i_op_b  = b;
        bus.i_flags = f;
        bus.i_valid = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_valid = 1'b0;
                check({nm, " busy"}, 32'(bus.o_ready), 32'd0);
            end
            if (bus.o_done) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        check({nm, " done seen"}, 32'(seen), 32'd1);
        check({nm, " latency"}, 32'(lat), 32'(elat));
        check({nm, " result"}, 32'(bus.o_result), 32'(er));
        check({nm, " flags"}, 32'(bus.o_flags), 32'(ef));
        @(negedge clk);
        check({nm, " done pulse"}, 32'(bus.o_done), 32'd0);
        check({nm, " result hold"}, 32'(bus.o_result), 32'(er));
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  f;
        logic [15:0] res;
        logic [7:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  seen;
        bit  any_done;

        vecs[0] = '{2'd0, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0, 4};
        vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30, 4};
        vecs[2] = '{2'd0, 16'h1234, 16'h0100, 8'h00, 16'h1334, 8'h00, 3};
        vecs[3] = '{2'd1, 16'h00FF, 16'h7777, 8'h5F, 16'h0100, 8'h50, 4};
        vecs[4] = '{2'd2, 16'h0000, 16'h3333, 8'hC0, 16'hFFFF, 8'hC0, 4};
        vecs[5] = '{2'd3, 16'hFFF8, 16'hAB08, 8'h00, 16'h0000, 8'h30, 4};
        vecs[6] = '{2'd3, 16'h0000, 16'h12FF, 8'hF0, 16'hFFFF, 8'h00, 3};
        vecs[7] = '{2'd0, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h10, 3};

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_cmd   = CMD_ADD16;
        bus.i_op_a  = '0;
        bus.i_op_b  = '0;
        bus.i_flags = '0;

        repeat (3) @(negedge clk);
        check("reset done", 32'(bus.o_done), 32'd0);
        check("reset result", 32'(bus.o_result), 32'd0);
        check("reset flags", 32'(bus.o_flags), 32'd0);
        check("reset alu_a", 32'(bus.o_alu_a), 32'd0);
        check("reset alu_op", 32'(bus.o_alu_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", 32'(bus.o_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].f,
                    vecs[i].res, vecs[i].flg, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // i_valid held high across two commands; mid-op command change
        @(negedge clk);
        wait_ready("b2b");
        bus.i_cmd   = CMD_ADD16;
        bus.i_op_a  = 16'h1234;
        bus.i_op_b  = 16'h0100;
        bus.i_flags = 8'h00;
        bus.i_valid = 1'b1;
        @(negedge clk);
        check("b2b busy1", 32'(bus.o_ready), 32'd0);
        bus.i_cmd   = CMD_DEC16;
        bus.i_op_a  = 16'h0100;
        bus.i_op_b  = 16'hFFFF;
        bus.i_flags = 8'h20;
        @(negedge clk);
        check("b2b busy2", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        check("b2b first done", 32'(bus.o_done), 32'd1);
        check("b2b first result", 32'(bus.o_result), 32'h1334);
        check("b2b first flags", 32'(bus.o_flags), 32'h00);
        check("b2b busy3", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        check("b2b ready again", 32'(bus.o_ready), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_valid = 1'b0;
            if (bus.o_done) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        check("b2b second seen", 32'(seen), 32'd1);
        check("b2b second latency", 32'(lat), 32'd4);
        check("b2b second result", 32'(bus.o_result), 32'h00FF);
        check("b2b second flags", 32'(bus.o_flags), 32'h20);

        // Reset asserted while the high byte is being computed
        @(negedge clk);
        wait_ready("rst-mid");
        bus.i_cmd   = CMD_INC16;
        bus.i_op_a  = 16'h00FF;
        bus.i_op_b  = 16'h0000;
        bus.i_flags = 8'h5F;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst done", 32'(bus.o_done), 32'd0);
        check("midrst result", 32'(bus.o_result), 32'd0);
        check("midrst flags", 32'(bus.o_flags), 32'd0);
        check("midrst alu_a", 32'(bus.o_alu_a), 32'd0);
        check("midrst alu_b", 32'(bus.o_alu_b), 32'd0);
        check("midrst alu_op", 32'(bus.o_alu_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst ready", 32'(bus.o_ready), 32'd1);
        any_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.o_done) any_done = 1'b1;
            @(negedge clk);
        end
        check("midrst no done", 32'(any_done), 32'd0);
        run_cmd(2'd1, 16'h0001, 16'h0000, 8'h00, 16'h0002, 8'h00, 3, "post-rst inc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
